// File: rtl/sseg_pkg.sv
// sseg_pkg: shared constants and helpers for the seven-segment scan path
package sseg_pkg;
  localparam int DIGIT_W = 4;
  localparam int REFRESH_BITS_DEF = 18;
  localparam logic [7:0] SSEG_ANODE_OFF = 8'hFF;
  function automatic logic [7:0] onehot_n(input int unsigned idx, input int unsigned n);
    onehot_n = (idx < n) ? (8'(1) << idx) : 8'h00;
  endfunction
endpackage

// File: rtl/sseg_scan_mux_if.sv
// sseg_scan_mux_if: digit data, update handshake and scan outputs of the scan mux
interface sseg_scan_mux_if
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 4
) ();
  localparam int IDX_W = $clog2(N_DIGITS);
  logic                          en;
  logic [DIGIT_W*N_DIGITS-1:0]   hex_in;
  logic [N_DIGITS-1:0]           dp_in;
  logic [N_DIGITS-1:0]           blank_in;
  logic                          upd_req;
  logic                          upd_ack;
  logic [DIGIT_W-1:0]            hex_out;
  logic                          dp_out;
  logic [N_DIGITS-1:0]           an_n;
  logic [IDX_W-1:0]              digit_idx;
  modport master (
    output en, hex_in, dp_in, blank_in, upd_req,
    input  upd_ack, hex_out, dp_out, an_n, digit_idx
  );
  modport slave (
    input  en, hex_in, dp_in, blank_in, upd_req,
    output upd_ack, hex_out, dp_out, an_n, digit_idx
  );
endinterface

// File: rtl/sseg_prescaler.sv
// sseg_prescaler: free-running digit-period counter with a one-cycle tick on wrap
module sseg_prescaler
  import sseg_pkg::*;
#(
  parameter int REFRESH_BITS = REFRESH_BITS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);
  logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
  // advance only while scanning; holds its value when disabled
  always_comb cnt_d = en ? cnt_q + REFRESH_BITS'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign tick = en & (&cnt_q);
endmodule

// File: rtl/sseg_scan_mux.sv
// sseg_scan_mux: tear-free time-multiplexed scan of shadowed hex digits
module sseg_scan_mux
  import sseg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int REFRESH_BITS = REFRESH_BITS_DEF
) (
  input logic clk,
  input logic reset,
  sseg_scan_mux_if.slave bus
);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_DIGITS - 1);
  logic                        tick, frame_end, cap;
  logic [IDX_W-1:0]            cur_dig_q, cur_dig_d;
  logic [DIGIT_W*N_DIGITS-1:0] sh_hex_q;
  logic [N_DIGITS-1:0]         sh_dp_q, sh_blank_q;
  logic                        ack_q;
  logic [DIGIT_W-1:0]          hex_q, hex_d;
  logic                        dp_q, dp_d;
  logic [N_DIGITS-1:0]         an_q, an_d;
  logic [IDX_W-1:0]            idx_q;
  logic [7:0]                  oh;
  sseg_prescaler #(.REFRESH_BITS(REFRESH_BITS)) u_pre (
    .clk  (clk),
    .reset(reset),
    .en   (bus.en),
    .tick (tick)
  );
  // digit stepping, frame boundary detection and capture qualification
  always_comb begin
    frame_end = tick & (cur_dig_q == LAST);
    cap       = bus.upd_req & (~bus.en | frame_end);
    cur_dig_d = tick ? ((cur_dig_q == LAST) ? '0 : cur_dig_q + IDX_W'(1)) : cur_dig_q;
  end
  // output selection from the shadow registers for the current digit
  always_comb begin
    oh    = onehot_n(32'(cur_dig_q), N_DIGITS);
    hex_d = sh_hex_q[{cur_dig_q, 2'b00} +: DIGIT_W];
    dp_d  = sh_dp_q[cur_dig_q];
    an_d  = bus.en ? ~(oh[N_DIGITS-1:0] & ~sh_blank_q) : SSEG_ANODE_OFF[N_DIGITS-1:0];
  end
  // scan position, shadow capture, ack pulse and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_dig_q  <= '0;
      sh_hex_q   <= '0;
      sh_dp_q    <= '0;
      sh_blank_q <= '0;
      ack_q      <= 1'b0;
      hex_q      <= '0;
      dp_q       <= 1'b0;
      an_q       <= SSEG_ANODE_OFF[N_DIGITS-1:0];
      idx_q      <= '0;
    end else begin
      cur_dig_q <= cur_dig_d;
      ack_q     <= cap;
      hex_q     <= hex_d;
      dp_q      <= dp_d;
      an_q      <= an_d;
      idx_q     <= cur_dig_q;
      if (cap) begin
        sh_hex_q   <= bus.hex_in;
        sh_dp_q    <= bus.dp_in;
        sh_blank_q <= bus.blank_in;
      end
    end
  end
  assign bus.upd_ack   = ack_q;
  assign bus.hex_out   = hex_q;
  assign bus.dp_out    = dp_q;
  assign bus.an_n      = an_q;
  assign bus.digit_idx = idx_q;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb_sseg_scan_mux: randomized and directed scan checks against a behavioural model
module tb_sseg_scan_mux;
  logic clk = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;

  sseg_scan_mux_if #(.N_DIGITS(4)) bus_a ();
  sseg_scan_mux_if #(.N_DIGITS(6)) bus_b ();

  sseg_scan_mux #(.N_DIGITS(4), .REFRESH_BITS(2)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
  sseg_scan_mux #(.N_DIGITS(6), .REFRESH_BITS(1)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int m_presc, m_dig;
  int m_hex[4], m_dp[4], m_blank[4];
  int e_hex, e_dp, e_an, e_idx, e_ack;
  int b_presc, b_dig, eb_an, eb_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit tick, fe, cap;
    if (reset) begin
      m_presc = 0; m_dig = 0;
      for (int k = 0; k < 4; k++) begin m_hex[k] = 0; m_dp[k] = 0; m_blank[k] = 0; end
      e_hex = 0; e_dp = 0; e_an = 'hF; e_idx = 0; e_ack = 0;
      b_presc = 0; b_dig = 0; eb_an = 'h3F; eb_idx = 0;
    end else begin
      tick = bus_a.en && (m_presc == 3);
      fe   = tick && (m_dig == 3);
      cap  = bus_a.upd_req && (!bus_a.en || fe);
      e_hex = m_hex[m_dig];
      e_dp  = m_dp[m_dig];
      e_idx = m_dig;
      e_an  = !bus_a.en ? 'hF : (m_blank[m_dig] != 0 ? 'hF : ('hF ^ (1 << m_dig)));
      e_ack = cap;
      if (cap)
        for (int k = 0; k < 4; k++) begin
          m_hex[k]   = (bus_a.hex_in >> (4 * k)) & 'hF;
          m_dp[k]    = bus_a.dp_in[k];
          m_blank[k] = bus_a.blank_in[k];
        end
      if (bus_a.en) m_presc = (m_presc + 1) % 4;
      if (tick) m_dig = (m_dig + 1) % 4;
      eb_idx = b_dig;
      eb_an  = 'h3F ^ (1 << b_dig);
      if (b_presc == 1) b_dig = (b_dig + 1) % 6;
      b_presc = (b_presc + 1) % 2;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("an_n", 32'(bus_a.an_n), e_an);
    check("digit_idx", 32'(bus_a.digit_idx), e_idx);
    check("hex_out", 32'(bus_a.hex_out), e_hex);
    check("dp_out", 32'(bus_a.dp_out), e_dp);
    check("upd_ack", 32'(bus_a.upd_ack), e_ack);
    check("b_an_n", 32'(bus_b.an_n), eb_an);
    check("b_digit_idx", 32'(bus_b.digit_idx), eb_idx);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_ack(input int bound);
    int i;
    for (i = 0; i < bound && e_ack == 0; i++) cyc();
    if (e_ack == 0) check("ack_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    bus_a.en = 1'b1; bus_a.hex_in = '0; bus_a.dp_in = '0; bus_a.blank_in = '0; bus_a.upd_req = 1'b0;
    bus_b.en = 1'b1; bus_b.hex_in = '0; bus_b.dp_in = '0; bus_b.blank_in = '0; bus_b.upd_req = 1'b0;
    run(2);
    reset = 1'b0;
    run(20);
    run(5);
    bus_a.hex_in = 16'hA3C5; bus_a.dp_in = 4'b0100; bus_a.upd_req = 1'b1;
    wait_ack(40);
    bus_a.upd_req = 1'b0;
    run(20);
    bus_a.blank_in = 4'b1010; bus_a.upd_req = 1'b1;
    wait_ack(40);
    bus_a.upd_req = 1'b0;
    run(20);
    bus_a.upd_req = 1'b1;
    wait_ack(40);
    wait_ack(40);
    bus_a.upd_req = 1'b0;
    for (int i = 0; i < 40 && m_dig != 2; i++) cyc();
    bus_a.en = 1'b0;
    run(2);
    bus_a.hex_in = 16'h1234; bus_a.blank_in = 4'b0000; bus_a.upd_req = 1'b1;
    cyc();
    bus_a.upd_req = 1'b0;
    run(2);
    bus_a.en = 1'b1;
    run(12);
    bus_a.upd_req = 1'b1; bus_a.en = 1'b0; reset = 1'b1;
    cyc();
    reset = 1'b0; bus_a.upd_req = 1'b0; bus_a.en = 1'b1;
    run(20);
    for (int i = 0; i < 600; i++) begin
      bus_a.en       = ($urandom_range(9) != 0);
      bus_a.upd_req  = ($urandom_range(3) == 0);
      bus_a.hex_in   = 16'($urandom);
      bus_a.dp_in    = 4'($urandom);
      bus_a.blank_in = 4'($urandom);
      reset          = ($urandom_range(199) == 0);
      cyc();
    end
    reset = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
